cmd_event_fifo: RTL and testbench

Command change-event recorder sitting directly downstream of the per-signal filter bank (FilterN). It compares the filtered command vector against its previous value and queues one event per changed command: index, new level and timestamp. It presents queued events on a valid/ready read port to the command-processing logic.

---
 rtl/cmd_event_fifo.sv | 132 +++++++++++++
 tb/tb_cmd_event_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_event_fifo.sv
// cmd_event_fifo: records one event per changed filtered command into a small FIFO.
// Each change is latched in a pending vector, granted lowest index first, and pushed
// as {index, level, timestamp}. Queued events are presented on a valid/ready port.
// Pending bits survive a full FIFO, so no change is lost. A second change that
// arrives before its first change was queued merges with it and raises the sticky
// ovf flag.
module cmd_event_fifo #(
   parameter  int NUM_SIGNALS = 16,
   parameter  int DEPTH       = 8,
   parameter  int TS_WIDTH    = 16,
   localparam int IDX_WIDTH   = $clog2(NUM_SIGNALS),
   localparam int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   aclr,
   input  logic [NUM_SIGNALS-1:0] in,
   input  logic                   rd_ready,
   input  logic                   ovf_clr,
   output logic                   rd_valid,
   output logic [IDX_WIDTH-1:0]   ev_index,
   output logic                   ev_level,
   output logic [TS_WIDTH-1:0]    ev_ts,
   output logic [CNT_WIDTH-1:0]   count,
   output logic                   ovf
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [IDX_WIDTH-1:0] idx;
      logic                 level;
      logic [TS_WIDTH-1:0]  ts;
   } event_t;

   logic [NUM_SIGNALS-1:0] prev_q;
   logic [NUM_SIGNALS-1:0] pending_q, pending_d;
   logic [NUM_SIGNALS-1:0] change;
   logic [NUM_SIGNALS-1:0] grant_mask;
   logic [IDX_WIDTH-1:0]   grant_idx;
   logic                   grant_any;
   logic                   push, pop;
   logic [TS_WIDTH-1:0]    ts_q;
   event_t                 mem_q [DEPTH];
   event_t                 wr_ev;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   ovf_set;

   // Change detect against the level captured at the previous edge.
   assign change = in ^ prev_q;

   // Fixed-priority pick of the lowest pending index; scanning downward lets the
   // last hit (the lowest set bit) win.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = NUM_SIGNALS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            grant_idx = IDX_WIDTH'(i);
            grant_any = 1'b1;
         end
      end
   end

   // A full FIFO blocks the grant even when the head is popped this cycle, so the
   // push decision depends on registered count only.
   assign push       = grant_any && (count_q < CNT_WIDTH'(DEPTH));
   assign pop        = (count_q != '0) && rd_ready;
   assign grant_mask = push ? (NUM_SIGNALS'(1) << grant_idx) : '0;

   // The level pushed is what the command was at the previous edge, i.e. the most
   // recent level the pending bit stands for.
   always_comb begin
      wr_ev       = '0;
      wr_ev.idx   = grant_idx;
      wr_ev.level = prev_q[grant_idx];
      wr_ev.ts    = ts_q;
   end

   // Next-state for pending, occupancy and the sticky overflow flag. A change on the
   // bit being granted just re-arms it and is not an overflow.
   always_comb begin
      pending_d = (pending_q & ~grant_mask) | change;
      count_d   = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      ovf_set   = |(change & pending_q & ~grant_mask);
      ovf_d     = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   // Change tracking, timestamp and flag state.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         prev_q    <= '0;
         pending_q <= '0;
         ts_q      <= '0;
         ovf_q     <= 1'b0;
      end else begin
         prev_q    <= in;
         pending_q <= pending_d;
         ts_q      <= ts_q + TS_WIDTH'(1);
         ovf_q     <= ovf_d;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Event storage; contents need no reset because validity comes from count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_ev;
   end

   assign rd_valid = (count_q != '0);
   assign ev_index = mem_q[rd_ptr_q].idx;
   assign ev_level = mem_q[rd_ptr_q].level;
   assign ev_ts    = mem_q[rd_ptr_q].ts;
   assign count    = count_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_cmd_event_fifo.sv
// Bench for cmd_event_fifo: two instances (16-bit and 4-bit timestamps) share the
// stimulus and are compared against a queue-based reference model every cycle.
module tb_cmd_event_fifo;

   logic        clk = 1'b0;
   logic        aclr = 1'b0;
   logic [15:0] in_s = '0;
   logic        rd_ready_s = 1'b0;
   logic        ovf_clr_s = 1'b0;

   logic        a_valid, a_level, a_ovf;
   logic [3:0]  a_index, a_count;
   logic [15:0] a_ts;
   logic        b_valid, b_level, b_ovf;
   logic [3:0]  b_index, b_count;
   logic [3:0]  b_ts;

   int n_cmp = 0;
   int n_mis = 0;

   cmd_event_fifo #(.NUM_SIGNALS(16), .DEPTH(8), .TS_WIDTH(16)) dut_a (
      .clk(clk), .aclr(aclr), .in(in_s), .rd_ready(rd_ready_s), .ovf_clr(ovf_clr_s),
      .rd_valid(a_valid), .ev_index(a_index), .ev_level(a_level), .ev_ts(a_ts),
      .count(a_count), .ovf(a_ovf));

   cmd_event_fifo #(.NUM_SIGNALS(16), .DEPTH(8), .TS_WIDTH(4)) dut_b (
      .clk(clk), .aclr(aclr), .in(in_s), .rd_ready(rd_ready_s), .ovf_clr(ovf_clr_s),
      .rd_valid(b_valid), .ev_index(b_index), .ev_level(b_level), .ev_ts(b_ts),
      .count(b_count), .ovf(b_ovf));

   always #5 clk = ~clk;

   // Reference model: a queue of events plus the set of commands awaiting a slot.
   typedef struct {
      int          idx;
      logic        lvl;
      logic [31:0] ts;
   } mev_t;

   mev_t        m_q[$];
   logic [15:0] m_prev;
   logic [15:0] m_pend;
   logic [31:0] m_ts;
   logic        m_ovf;

   task automatic m_reset();
      m_q.delete();
      m_prev = '0;
      m_pend = '0;
      m_ts   = '0;
      m_ovf  = 1'b0;
   endtask

   task automatic m_edge(input logic [15:0] vin, input logic rr, input logic oc);
      logic [15:0] chg, gm;
      int          pre;
      mev_t        e;
      chg = vin ^ m_prev;
      gm  = '0;
      pre = m_q.size();
      if (m_pend != 0 && pre < 8) begin
         for (int i = 0; i < 16; i++) begin
            if (m_pend[i]) begin
               e.idx = i; e.lvl = m_prev[i]; e.ts = m_ts;
               m_q.push_back(e);
               gm[i] = 1'b1;
               break;
            end
         end
      end
      if (pre > 0 && rr) void'(m_q.pop_front());
      if ((chg & m_pend & ~gm) != 0) m_ovf = 1'b1;
      else if (oc)                   m_ovf = 1'b0;
      m_pend = (m_pend & ~gm) | chg;
      m_prev = vin;
      m_ts   = m_ts + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("a_valid", 32'(a_valid), 32'(m_q.size() != 0));
      check("b_valid", 32'(b_valid), 32'(m_q.size() != 0));
      check("a_count", 32'(a_count), 32'(m_q.size()));
      check("b_count", 32'(b_count), 32'(m_q.size()));
      check("a_ovf",   32'(a_ovf),   32'(m_ovf));
      check("b_ovf",   32'(b_ovf),   32'(m_ovf));
      if (m_q.size() != 0) begin
         check("a_index", 32'(a_index), 32'(m_q[0].idx));
         check("a_level", 32'(a_level), 32'(m_q[0].lvl));
         check("a_ts",    32'(a_ts),    32'(m_q[0].ts[15:0]));
         check("b_index", 32'(b_index), 32'(m_q[0].idx));
         check("b_ts",    32'(b_ts),    32'(m_q[0].ts[3:0]));
      end
   endtask

   // Drive at the falling edge, let the model take the rising edge, compare at the next fall.
   task automatic step(input logic [15:0] vin, input logic rr, input logic oc);
      in_s = vin; rd_ready_s = rr; ovf_clr_s = oc;
      @(posedge clk);
      m_edge(vin, rr, oc);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      logic [15:0] cur;
      m_reset();
      #1 aclr = 1'b1;
      #2;
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_count", 32'(a_count), 32'd0);
      check("rst_ovf",   32'(a_ovf),   32'd0);

      // Reset release with two commands already high.
      cur = 16'h0005;
      in_s = cur;
      @(negedge clk);
      aclr = 1'b0;
      step(cur, 1'b0, 1'b0);
      check("t1_notyet", 32'(a_valid), 32'd0);
      step(cur, 1'b0, 1'b0);
      check("t1_idx0", 32'(a_index), 32'd0);
      check("t1_ts1",  32'(a_ts),    32'd1);
      step(cur, 1'b0, 1'b0);
      check("t1_cnt2", 32'(a_count), 32'd2);
      repeat (2) step(cur, 1'b0, 1'b0);

      // Drain, then two simultaneous rises with the consumer always ready.
      cur = 16'h0000;
      repeat (12) step(cur, 1'b1, 1'b0);
      cur = 16'h8001;
      repeat (5) begin
         step(cur, 1'b1, 1'b0);
         check("t2_cnt_le1", 32'(a_count <= 4'd1), 32'd1);
      end

      // Ten rises against an 8-deep FIFO, then drain: nothing may be lost.
      cur = 16'h87FF;
      repeat (14) step(cur, 1'b0, 1'b0);
      check("t3_full", 32'(a_count), 32'd8);
      check("t3_ovf0", 32'(a_ovf),   32'd0);
      repeat (14) step(cur, 1'b1, 1'b0);

      // Fill, then merge toggles on command 3 while full.
      step(cur, 1'b0, 1'b1);
      cur ^= 16'hFF00;
      repeat (10) step(cur, 1'b0, 1'b0);
      check("t4_full", 32'(a_count), 32'd8);
      cur ^= 16'h0008; step(cur, 1'b0, 1'b0);
      check("t4_noovf", 32'(a_ovf), 32'd0);
      cur ^= 16'h0008; step(cur, 1'b0, 1'b0);
      check("t4_ovf", 32'(a_ovf), 32'd1);
      step(cur, 1'b0, 1'b1);
      check("t4_clr", 32'(a_ovf), 32'd0);
      cur ^= 16'h0008; step(cur, 1'b0, 1'b1);
      check("t4_setwins", 32'(a_ovf), 32'd1);
      cur ^= 16'h0008; step(cur, 1'b0, 1'b0);
      repeat (14) step(cur, 1'b1, 1'b0);

      // Command 4 changes on the very cycle its pending change is granted.
      step(cur, 1'b1, 1'b1);
      cur ^= 16'h0010; step(cur, 1'b1, 1'b0);
      cur ^= 16'h0010; step(cur, 1'b1, 1'b0);
      check("t5_ovf0", 32'(a_ovf), 32'd0);
      repeat (6) step(cur, 1'b1, 1'b0);

      // Asynchronous reset with three events queued.
      cur ^= 16'h0007;
      repeat (5) step(cur, 1'b0, 1'b0);
      check("t6_cnt3", 32'(a_count), 32'd3);
      #2 aclr = 1'b1;
      #1;
      m_reset();
      check("t6_valid", 32'(a_valid), 32'd0);
      check("t6_count", 32'(a_count), 32'd0);
      check("t6_bcount", 32'(b_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      aclr = 1'b0;
      repeat (10) step(cur, 1'b1, 1'b0);

      // Random traffic; runs long enough for the 4-bit timestamp to wrap many times.
      repeat (400) begin
         if ($urandom_range(0, 2) == 0) cur ^= 16'(1) << $urandom_range(0, 15);
         step(cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      end
      repeat (20) step(cur, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
